// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  localparam logic [1:0]  CAUSE_NONE       = 2'b00;
  localparam logic [1:0]  CAUSE_MISALIGN   = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT    = 2'b10;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Saturating stall counter; expired is high once TIMEOUT-1 un-acked strobe cycles have elapsed.
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests instruction memory and holds
// the fetched word for decode behind a valid/ready handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_stb,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic stb, complete, consume, wd_expired, timeout;

  // Redirect kills the strobe so an ack landing in the same cycle is dropped.
  assign stb      = (state_q == ST_FETCH) && !i_redirect && (!valid_q || i_ready);
  assign complete = stb && i_imem_ack;
  assign consume  = valid_q && i_ready;
  assign timeout  = stb && !i_imem_ack && wd_expired;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!stb || i_imem_ack),
    .inc     (stb && !i_imem_ack),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    fault_d = fault_q;
    cause_d = cause_q;

    if (i_redirect) begin
      valid_d = 1'b0;
      instr_d = NOP;
      if (is_aligned(i_redirect_pc)) begin
        pc_d    = i_redirect_pc;
        state_d = ST_FETCH;
        fault_d = 1'b0;
        cause_d = CAUSE_NONE;
      end else begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
        cause_d = CAUSE_MISALIGN;
      end
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_FETCH: begin
          if (timeout) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        default:  state_d = state_q;
      endcase

      if (complete) begin
        instr_d = i_imem_data;
        opc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end else if (consume) begin
        valid_d = 1'b0;
        instr_d = NOP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      opc_q   <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign o_imem_addr   = pc_q;
  assign o_imem_stb    = stb;
  assign o_valid       = valid_q;
  assign o_instr       = instr_q;
  assign o_pc          = opc_q;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, faults, wrap and async reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam logic [31:0] DOFS  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] o_imem_addr;
  logic        o_imem_stb;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_fault;
  logic [1:0]  o_fault_cause;
  logic        ack_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory that acks combinationally and returns an address-derived word.
  assign i_imem_ack  = ack_en;
  assign i_imem_data = o_imem_addr + DOFS;

  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(16), .NOP(32'h0000_0013)) dut (
    .clk           (clk),
    .rst           (rst),
    .o_imem_addr   (o_imem_addr),
    .o_imem_stb    (o_imem_stb),
    .i_imem_ack    (i_imem_ack),
    .i_imem_data   (i_imem_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_fault       (o_fault),
    .o_fault_cause (o_fault_cause)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; i_ready = 1'b1; ack_en = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, NOP_W);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_stb", 32'(o_imem_stb), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_cause", 32'(o_fault_cause), 32'd0);

    rst = 1'b0;
    #1 chk("idle_stb", 32'(o_imem_stb), 32'd0);
    tick();
    chk("fetch_stb", 32'(o_imem_stb), 32'd1);
    chk("fetch_addr", o_imem_addr, 32'h0);
    chk("fetch_valid0", 32'(o_valid), 32'd0);
    tick();
    chk("seq0_valid", 32'(o_valid), 32'd1);
    chk("seq0_pc", o_pc, 32'h0);
    chk("seq0_instr", o_instr, 32'h1000_0000);
    tick();
    chk("seq1_valid", 32'(o_valid), 32'd1);
    chk("seq1_pc", o_pc, 32'h4);
    tick();
    chk("seq2_valid", 32'(o_valid), 32'd1);
    chk("seq2_pc", o_pc, 32'h8);
    chk("seq2_instr", o_instr, 32'h1000_0008);
    chk("seq2_addr", o_imem_addr, 32'hC);

    i_ready = 1'b0;
    #1 chk("bp_stb", 32'(o_imem_stb), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_pc", o_pc, 32'h8);
      chk("bp_addr", o_imem_addr, 32'hC);
      chk("bp_instr", o_instr, 32'h1000_0008);
      chk("bp_stb_hold", 32'(o_imem_stb), 32'd0);
    end
    i_ready = 1'b1;
    #1 chk("rel_stb", 32'(o_imem_stb), 32'd1);
    tick();
    chk("rel_pc", o_pc, 32'hC);
    chk("rel_instr", o_instr, 32'h1000_000C);
    chk("rel_addr", o_imem_addr, 32'h10);

    i_redirect = 1'b1; i_redirect_pc = 32'h100;
    #1 chk("redir_stb", 32'(o_imem_stb), 32'd0);
    tick();
    chk("redir_valid", 32'(o_valid), 32'd0);
    chk("redir_instr", o_instr, NOP_W);
    chk("redir_addr", o_imem_addr, 32'h100);
    i_redirect = 1'b0;
    tick();
    chk("redir_pc", o_pc, 32'h100);
    chk("redir_valid1", 32'(o_valid), 32'd1);
    chk("redir_data", o_instr, 32'h1000_0100);

    i_redirect = 1'b1; i_redirect_pc = 32'h102;
    tick();
    i_redirect = 1'b0;
    chk("mis_fault", 32'(o_fault), 32'd1);
    chk("mis_cause", 32'(o_fault_cause), 32'd1);
    chk("mis_valid", 32'(o_valid), 32'd0);
    chk("mis_addr", o_imem_addr, 32'h104);
    repeat (2) tick();
    chk("mis_stb", 32'(o_imem_stb), 32'd0);
    chk("mis_sticky", 32'(o_fault), 32'd1);

    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    tick();
    chk("clr_fault", 32'(o_fault), 32'd0);
    chk("clr_cause", 32'(o_fault_cause), 32'd0);
    chk("clr_addr", o_imem_addr, 32'h200);
    i_redirect = 1'b0;
    #1 chk("clr_stb", 32'(o_imem_stb), 32'd1);
    tick();
    chk("clr_pc", o_pc, 32'h200);
    chk("clr_valid", 32'(o_valid), 32'd1);

    ack_en = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!o_imem_stb) break;
      n++;
      tick();
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_fault", 32'(o_fault), 32'd1);
    chk("to_cause", 32'(o_fault_cause), 32'd2);
    chk("to_stb", 32'(o_imem_stb), 32'd0);
    chk("to_addr", o_imem_addr, 32'h204);

    ack_en = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    tick();
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", o_imem_addr, 32'h0);
    chk("wrap_fault", 32'(o_fault), 32'd0);

    i_redirect = 1'b1; i_redirect_pc = 32'h40;
    tick();
    i_redirect = 1'b0;
    tick();
    chk("pre_rst_pc", o_pc, 32'h40);
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_instr", o_instr, NOP_W);
    chk("arst_pc", o_pc, 32'h0);
    chk("arst_addr", o_imem_addr, 32'h0);
    chk("arst_stb", 32'(o_imem_stb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("restart_stb", 32'(o_imem_stb), 32'd1);
    chk("restart_addr", o_imem_addr, 32'h0);
    tick();
    chk("restart_pc", o_pc, 32'h0);
    chk("restart_valid", 32'(o_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
